// File: rtl/clk_tap_router_pkg.sv
// Shared definitions for the clock tap router: FSM state encodings,
// default sizing and a select-width helper.
package clk_tap_router_pkg;

    localparam int N_TAPS_DEF = 8;
    localparam int N_OUT_DEF  = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ARM   = 2'd2
    } route_state_t;

    // Keeps select buses at least one bit wide for single-entry configurations.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_tap_router_tap_counter.sv
// Free-running binary counter whose bits are the divided clock taps.
// Bit i has a period of 2^(i+1) clk cycles while en is high.
module tap_counter #(
    parameter int N_TAPS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    output logic [N_TAPS-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + N_TAPS'(1);
        end
    end

endmodule

// File: rtl/clk_tap_router.sv
// Divided-clock tap generator with a glitch-free tap-to-output router.
// Route changes are requested with req and applied through a drain/arm sequence.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | active route drives f; req captures a new pending route
//   ST_DRAIN | old route still drives f until its tap is low, then f=0
//   ST_ARM   | f held low until the pending tap is low, then route swaps
module clk_tap_router
    import clk_tap_router_pkg::*;
#(
    parameter  int N_TAPS = N_TAPS_DEF,
    parameter  int N_OUT  = N_OUT_DEF,
    localparam int SEL_W  = sel_width(N_TAPS),
    localparam int OSEL_W = sel_width(N_OUT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              req,
    input  logic [SEL_W-1:0]  s_mux,
    input  logic [OSEL_W-1:0] s_demux,
    output logic              busy,
    output logic              done,
    output logic [N_TAPS-1:0] taps,
    output logic [N_OUT-1:0]  f
);

    logic [N_TAPS-1:0] cnt;
    route_state_t      state;
    logic [SEL_W-1:0]  act_mux;
    logic [SEL_W-1:0]  pend_mux;
    logic [OSEL_W-1:0] act_demux;
    logic [OSEL_W-1:0] pend_demux;

    tap_counter #(
        .N_TAPS (N_TAPS)
    ) u_tap_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .cnt     (cnt)
    );

    assign taps = cnt;

    function automatic logic [SEL_W-1:0] clamp_mux(input logic [SEL_W-1:0] s);
        if (int'(s) >= N_TAPS) begin
            return SEL_W'(N_TAPS - 1);
        end
        return s;
    endfunction

    function automatic logic [OSEL_W-1:0] clamp_demux(input logic [OSEL_W-1:0] s);
        if (int'(s) >= N_OUT) begin
            return OSEL_W'(N_OUT - 1);
        end
        return s;
    endfunction

    function automatic logic [N_OUT-1:0] route_vec(input logic bit_v,
                                                   input logic [OSEL_W-1:0] sel);
        logic [N_OUT-1:0] v;
        v      = '0;
        v[sel] = bit_v;
        return v;
    endfunction

    // Waiting for a low tap on both sides of the swap means the old output
    // finishes on a full low and the new one begins with a full high phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            act_mux    <= '0;
            act_demux  <= '0;
            pend_mux   <= '0;
            pend_demux <= '0;
            f          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    f <= route_vec(cnt[act_mux], act_demux);
                    if (req) begin
                        pend_mux   <= clamp_mux(s_mux);
                        pend_demux <= clamp_demux(s_demux);
                        busy       <= 1'b1;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!cnt[act_mux]) begin
                        f     <= '0;
                        state <= ST_ARM;
                    end else begin
                        f <= route_vec(cnt[act_mux], act_demux);
                    end
                end
                ST_ARM: begin
                    f <= '0;
                    if (!cnt[pend_mux]) begin
                        act_mux   <= pend_mux;
                        act_demux <= pend_demux;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                default: begin
                    f     <= '0;
                    busy  <= 1'b0;
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
